// File: rtl/neq_assert_monitor.sv
// Multi-channel monitor for the property q != d(delayed by LAT); counts and flags violations.
// Latency: fail is registered one cycle after the compare cycle; compare uses d/valid from LAT cycles earlier.
// Backpressure: none; the monitor observes every cycle and never stalls the observed path.
module neq_assert_monitor #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  logic                                    mclk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    clr,
    input  logic                                    stop_on_fail,
    input  logic [NCH-1:0]                          valid,
    input  logic [NCH*W-1:0]                        d,
    input  logic [NCH*W-1:0]                        q,
    output logic [NCH-1:0]                          fail,
    output logic                                    err_sticky,
    output logic [CNT_W-1:0]                        fail_cnt,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch,
    output logic [1:0]                              state
);

    localparam int FCW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ARM_N = (LAT > 0) ? LAT : 1;
    localparam int SW    = CNT_W + 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               st;
    logic [3:0]           arm_cnt;
    logic                 push_en;
    logic                 flush;
    logic [NCH-1:0]       push_v;
    logic [NCH-1:0]       cmp_v;
    logic [NCH*W-1:0]     cmp_d;
    logic [NCH-1:0]       viol_run;
    logic [SW-1:0]        sum;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [FCW-1:0]       fc_nxt;

    assign state   = st;
    assign push_en = en && (st == S_ARMED || st == S_RUN);
    assign push_v  = valid & {NCH{push_en}};
    // Dropping out of ARMED/RUN throws away in-flight samples so a re-arm refills from scratch.
    assign flush   = clr || (!en && st != S_HALT);

    generate
        if (LAT == 0) begin : g_direct
            assign cmp_v = push_v;
            assign cmp_d = d;
        end else begin : g_dline
            logic [NCH-1:0]   dv [LAT];
            logic [NCH*W-1:0] dd [LAT];

            always_ff @(posedge mclk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < LAT; k++) begin
                        dv[k] <= '0;
                        dd[k] <= '0;
                    end
                end else if (flush) begin
                    for (int k = 0; k < LAT; k++) begin
                        dv[k] <= '0;
                        dd[k] <= '0;
                    end
                end else begin
                    dv[0] <= push_v;
                    dd[0] <= d;
                    for (int k = 1; k < LAT; k++) begin
                        dv[k] <= dv[k-1];
                        dd[k] <= dd[k-1];
                    end
                end
            end

            assign cmp_v = dv[LAT-1];
            assign cmp_d = dd[LAT-1];
        end
    endgenerate

    always_comb begin
        viol_run = '0;
        for (int i = 0; i < NCH; i++) begin
            viol_run[i] = cmp_v[i] && (q[i*W +: W] == cmp_d[i*W +: W]) && (st == S_RUN) && en;
        end
    end

    always_comb begin
        sum    = SW'(fail_cnt);
        fc_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SW'(viol_run[i]);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol_run[i]) fc_nxt = FCW'(i);
        end
        cnt_nxt = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            st         <= S_IDLE;
            arm_cnt    <= '0;
            fail       <= '0;
            err_sticky <= 1'b0;
            fail_cnt   <= '0;
            first_ch   <= '0;
        end else if (clr) begin
            st         <= S_IDLE;
            arm_cnt    <= '0;
            fail       <= '0;
            err_sticky <= 1'b0;
            fail_cnt   <= '0;
            first_ch   <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    fail    <= '0;
                    arm_cnt <= '0;
                    if (en) st <= S_ARMED;
                end
                S_ARMED: begin
                    fail <= '0;
                    if (!en) begin
                        st <= S_IDLE;
                    end else if (arm_cnt == 4'(ARM_N - 1)) begin
                        st <= S_RUN;
                    end else begin
                        arm_cnt <= arm_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    fail <= viol_run;
                    if (|viol_run) begin
                        fail_cnt   <= cnt_nxt;
                        err_sticky <= 1'b1;
                        if (!err_sticky) first_ch <= fc_nxt;
                    end
                    if (!en) begin
                        st <= S_IDLE;
                    end else if (stop_on_fail && |viol_run) begin
                        st <= S_HALT;
                    end
                end
                default: begin
                    // HALT: everything frozen until clr or rst.
                    fail <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neq_assert_monitor.sv
// Scoreboarded bench: u0 runs LAT=2 with default counter width, u1 runs LAT=0 with a 2-bit counter.
module tb_neq_assert_monitor;

    logic       mclk = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       clr  = 1'b0;
    logic       sof  = 1'b0;
    logic [3:0] valid = '0;
    logic [3:0] d     = '0;
    logic [3:0] q     = '0;

    logic [3:0] fail0, fail1;
    logic       err0, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [1:0] fc0, fc1, st0, st1;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] F  = 4'hF;
    localparam logic [3:0] D  = 4'b1010;
    localparam logic [3:0] NQ = 4'b0101;

    always #5 mclk = ~mclk;

    neq_assert_monitor #(.NCH(4), .W(1), .LAT(2), .CNT_W(8)) u0 (
        .mclk(mclk), .rst(rst), .en(en), .clr(clr), .stop_on_fail(sof),
        .valid(valid), .d(d), .q(q),
        .fail(fail0), .err_sticky(err0), .fail_cnt(cnt0), .first_ch(fc0), .state(st0)
    );

    neq_assert_monitor #(.NCH(4), .W(1), .LAT(0), .CNT_W(2)) u1 (
        .mclk(mclk), .rst(rst), .en(en), .clr(clr), .stop_on_fail(sof),
        .valid(valid), .d(d), .q(q),
        .fail(fail1), .err_sticky(err1), .fail_cnt(cnt1), .first_ch(fc1), .state(st1)
    );

    typedef struct {
        int         inst;
        logic [3:0] f;
        logic [7:0] c;
        logic       e;
        logic [1:0] fc;
        logic [1:0] st;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t x;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    task automatic step(input logic e_, input logic c_, input logic s_,
                        input logic [3:0] v_, input logic [3:0] d_, input logic [3:0] q_,
                        input int inst, input logic [3:0] ef, input logic [7:0] ec,
                        input logic ee, input logic [1:0] efc, input logic [1:0] est,
                        input string nm);
        exp_t t;
        @(negedge mclk);
        en = e_; clr = c_; sof = s_; valid = v_; d = d_; q = q_;
        t.inst = inst; t.f = ef; t.c = ec; t.e = ee; t.fc = efc; t.st = est; t.nm = nm;
        sb.push_back(t);
    endtask

    // Monitor: one expectation per clocked step, checked just after the edge.
    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.inst == 0) begin
                    cmp({x.nm, ".fail"},  32'(fail0), 32'(x.f));
                    cmp({x.nm, ".cnt"},   32'(cnt0),  32'(x.c));
                    cmp({x.nm, ".err"},   32'(err0),  32'(x.e));
                    cmp({x.nm, ".first"}, 32'(fc0),   32'(x.fc));
                    cmp({x.nm, ".state"}, 32'(st0),   32'(x.st));
                end else begin
                    cmp({x.nm, ".fail"},  32'(fail1), 32'(x.f));
                    cmp({x.nm, ".cnt"},   32'(cnt1),  32'(x.c));
                    cmp({x.nm, ".err"},   32'(err1),  32'(x.e));
                    cmp({x.nm, ".first"}, 32'(fc1),   32'(x.fc));
                    cmp({x.nm, ".state"}, 32'(st1),   32'(x.st));
                end
            end
        end
    end

    initial begin
        #2;
        cmp("rst.fail",  32'(fail0), 0);
        cmp("rst.cnt",   32'(cnt0),  0);
        cmp("rst.err",   32'(err0),  0);
        cmp("rst.first", 32'(fc0),   0);
        cmp("rst.state", 32'(st0),   0);
        cmp("rst.state1", 32'(st1),  0);
        @(negedge mclk);
        rst = 1'b0;

        // Basic run: q = ~d, then a single-channel violation on ch2.
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "arm1");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "arm2");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "run0");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "run_ok1");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "run_ok2");
        step(1,0,0, F,D,4'b0001, 0, 4'b0100,1,1,2,2, "viol_ch2");
        step(1,0,0, F,D,NQ,      0, 4'b0000,1,1,2,2, "after_ch2");

        // stop_on_fail with channels 1 and 3 violating together.
        step(1,1,0, F,D,NQ,      0, 4'b0000,0,0,0,0, "clr1");
        step(1,0,1, F,D,NQ,      0, 4'b0000,0,0,0,1, "sof_arm1");
        step(1,0,1, F,D,NQ,      0, 4'b0000,0,0,0,1, "sof_arm2");
        step(1,0,1, F,D,NQ,      0, 4'b0000,0,0,0,2, "sof_run");
        step(1,0,1, F,D,4'b1111, 0, 4'b1010,2,1,1,3, "viol_ch13");
        step(1,0,1, F,D,D,       0, 4'b0000,2,1,1,3, "halt_eq");
        step(0,0,1, F,D,D,       0, 4'b0000,2,1,1,3, "halt_en0");
        step(0,1,0, F,D,NQ,      0, 4'b0000,0,0,0,0, "clr_halt");

        // clr beats a simultaneous violation.
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "c_arm1");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "c_arm2");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "c_run");
        step(1,1,0, F,D,4'b1111, 0, 4'b0000,0,0,0,0, "clr_vs_viol");

        // Asynchronous reset in the middle of RUN.
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "r_arm1");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "r_arm2");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "r_run");
        step(1,0,0, F,D,4'b0001, 0, 4'b0100,1,1,2,2, "r_viol");
        @(negedge mclk);
        q = NQ;
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        cmp("arst.fail",  32'(fail0), 0);
        cmp("arst.cnt",   32'(cnt0),  0);
        cmp("arst.err",   32'(err0),  0);
        cmp("arst.first", 32'(fc0),   0);
        cmp("arst.state", 32'(st0),   0);
        @(negedge mclk);
        rst = 1'b0;
        step(0,0,0, F,D,NQ,      0, 4'b0000,0,0,0,0, "post_rst_idle");

        // Invalid sample with q == d must not flag; the next valid one flags all four.
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,1, "v_arm1");
        step(1,0,0, 4'b0000,D,NQ,0, 4'b0000,0,0,0,1, "v_arm2");
        step(1,0,0, F,D,NQ,      0, 4'b0000,0,0,0,2, "v_run");
        step(1,0,0, F,D,D,       0, 4'b0000,0,0,0,2, "invalid_eq");
        step(1,0,0, F,D,D,       0, 4'b1111,4,1,0,2, "all4");

        // LAT=0 instance with a 2-bit saturating counter.
        step(0,1,0, F,D,NQ,           1, 4'b0000,0,0,0,0, "u1_clr");
        step(1,0,0, F,D,NQ,           1, 4'b0000,0,0,0,1, "u1_arm");
        step(1,0,0, F,D,NQ,           1, 4'b0000,0,0,0,2, "u1_run");
        step(1,0,0, 4'b1110,D,4'b0100,1, 4'b0000,0,0,0,2, "u1_inv0");
        step(1,0,0, 4'b0001,D,4'b0100,1, 4'b0001,1,1,0,2, "u1_sat1");
        step(1,0,0, 4'b0001,D,4'b0100,1, 4'b0001,2,1,0,2, "u1_sat2");
        step(1,0,0, 4'b0001,D,4'b0100,1, 4'b0001,3,1,0,2, "u1_sat3");
        step(1,0,0, 4'b0001,D,4'b0100,1, 4'b0001,3,1,0,2, "u1_sat4");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge mclk);
        #2;
        cmp("drain", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
